// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle between the pin wrapper and the bit-serial adder.
// Optional cin member exists only when SERADD_CARRY_IN_EN is defined.
interface serial_adder_seq_if #(
   parameter int WIDTH = 4
);
   logic             ena;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERADD_CARRY_IN_EN
   logic             cin;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH:0]   sum;

`ifdef SERADD_CARRY_IN_EN
   modport master (output ena, start, a, b, cin, input busy, done, sum);
   modport slave  (input ena, start, a, b, cin, output busy, done, sum);
`else
   modport master (output ena, start, a, b, input busy, done, sum);
   modport slave  (input ena, start, a, b, output busy, done, sum);
`endif
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder: start accepted in IDLE, done pulses WIDTH cycles later, ena=0 freezes all state.
// Optional carry-in via SERADD_CARRY_IN_EN; start outside IDLE is dropped, not queued.
module serial_adder_seq #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   serial_adder_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] res_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   sum_q;

   logic             s1, c1, s, c2, carry_next, last_bit, cin_load;
   logic [WIDTH-1:0] res_next;

   // full add built from two half-adder steps
   always_comb begin
      s1         = a_sr[0] ^ b_sr[0];
      c1         = a_sr[0] & b_sr[0];
      s          = s1 ^ carry;
      c2         = s1 & carry;
      carry_next = c1 | c2;
      res_next   = {s, res_sr};
      last_bit   = (cnt == CW'(WIDTH - 1));
   end

`ifdef SERADD_CARRY_IN_EN
   assign cin_load = bus.cin;
`else
   assign cin_load = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
      end else if (bus.ena) begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  res_sr <= '0;
                  carry  <= cin_load;
                  cnt    <= '0;
                  state  <= S_ADD;
               end
            end
            S_ADD: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= carry_next;
               res_sr <= res_next[WIDTH-1:1];
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  // the final sum bit is still in flight, so take it from res_next
                  sum_q <= {carry_next, res_next};
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == S_ADD);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_q;
endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomised and directed bench for serial_adder_seq against an arithmetic reference model.
// Honours SERADD_CARRY_IN_EN for the carry-in cases.
module tb_serial_adder_seq;
   localparam int W = 4;
`ifdef SERADD_CARRY_IN_EN
   localparam bit CIN_EN = 1'b1;
`else
   localparam bit CIN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   serial_adder_seq_if #(.WIDTH(W)) bus ();

   serial_adder_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int r;
      r = int'(a) + int'(b) + ((CIN_EN && cin) ? 1 : 0);
      return (W+1)'(r);
   endfunction

   task automatic set_cin(input logic v);
`ifdef SERADD_CARRY_IN_EN
      bus.cin = v;
`endif
   endtask

   // Launches one add from IDLE and observes it at negedges until done has fallen.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int stall_k, input int stall_len, input int poke_k,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output logic [W:0] s_done, output logic [W:0] s_after);
      bus.a = a;
      bus.b = b;
      set_cin(cin);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      set_cin(1'($urandom));
      lat = -1; busy_cnt = 0; done_cnt = 0; s_done = '0; s_after = '0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = k;
               s_done = bus.sum;
            end
         end else if (lat >= 0) begin
            s_after = bus.sum;
            break;
         end
         if (stall_len > 0 && k == stall_k) bus.ena = 1'b0;
         if (stall_len > 0 && k == stall_k + stall_len) bus.ena = 1'b1;
         if (k == poke_k) begin
            bus.start = 1'b1;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
         end else if (k == poke_k + 1) begin
            bus.start = 1'b0;
         end
      end
      bus.ena = 1'b1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0) begin
         errors++;
         $display("FAIL reset_values busy=%b done=%b sum=%h expected 0/0/0", bus.busy, bus.done, bus.sum);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0) begin
            errors++;
            $display("FAIL idle_quiet cyc=%0d busy=%b done=%b sum=%h expected 0/0/0", i, bus.busy, bus.done, bus.sum);
         end
      end
   endtask

   task automatic test_basic;
      int lat, bc, dc;
      logic [W:0] sd, sa;
      do_op(4'hF, 4'h1, 1'b0, -1, 0, -10, lat, bc, dc, sd, sa);
      checks++;
      if (lat !== W || bc !== W || dc !== 1) begin
         errors++;
         $display("FAIL basic_timing lat=%0d busy=%0d dones=%0d expected %0d/%0d/1", lat, bc, dc, W, W);
      end
      checks++;
      if (sd !== 5'h10 || sa !== 5'h10) begin
         errors++;
         $display("FAIL basic_sum got=%h held=%h expected 10", sd, sa);
      end
   endtask

   task automatic test_back_to_back;
      logic       bl[12];
      logic       dl[12];
      logic [W:0] sl[12];
      int         dones;
      bus.a = 4'h5;
      bus.b = 4'hA;
      set_cin(1'b0);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.a = 4'h0;
      bus.b = 4'h0;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         bl[k] = bus.busy;
         dl[k] = bus.done;
         sl[k] = bus.sum;
         if (bus.done) dones++;
         if (k == 6) bus.start = 1'b0;
      end
      checks++;
      if (dl[4] !== 1'b1 || sl[4] !== 5'h0F) begin
         errors++;
         $display("FAIL b2b_first done=%b sum=%h expected 1/0f", dl[4], sl[4]);
      end
      checks++;
      if (bl[5] !== 1'b0 || bl[6] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_reaccept busy5=%b busy6=%b expected 0/1", bl[5], bl[6]);
      end
      checks++;
      if (dl[10] !== 1'b1 || sl[10] !== 5'h00 || dl[11] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second done=%b sum=%h after=%b expected 1/00/0", dl[10], sl[10], dl[11]);
      end
      checks++;
      if (dones !== 2) begin
         errors++;
         $display("FAIL b2b_done_count got=%0d expected 2", dones);
      end
   endtask

   task automatic test_start_ignored;
      int lat, bc, dc;
      logic [W:0] sd, sa;
      do_op(4'h3, 4'h6, 1'b0, -1, 0, 1, lat, bc, dc, sd, sa);
      checks++;
      if (sd !== 5'h09 || dc !== 1 || lat !== W) begin
         errors++;
         $display("FAIL start_ignored sum=%h dones=%0d lat=%0d expected 09/1/%0d", sd, dc, lat, W);
      end
   endtask

   task automatic test_stall;
      int lat, bc, dc;
      logic [W:0] sd, sa;
      do_op(4'h9, 4'h7, 1'b0, 1, 3, -10, lat, bc, dc, sd, sa);
      checks++;
      if (lat !== W + 3 || bc !== W + 3 || dc !== 1) begin
         errors++;
         $display("FAIL stall_timing lat=%0d busy=%0d dones=%0d expected %0d/%0d/1", lat, bc, dc, W + 3, W + 3);
      end
      checks++;
      if (sd !== 5'h10) begin
         errors++;
         $display("FAIL stall_sum got=%h expected 10", sd);
      end
   endtask

   task automatic test_reset_mid;
      int seen_done;
      bus.a = 4'hC;
      bus.b = 4'h5;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== '0) begin
         errors++;
         $display("FAIL reset_mid busy=%b done=%b sum=%h expected 0/0/0", bus.busy, bus.done, bus.sum);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done++;
      end
      checks++;
      if (seen_done !== 0 || bus.sum !== '0) begin
         errors++;
         $display("FAIL reset_mid_after activity=%0d sum=%h expected 0/00", seen_done, bus.sum);
      end
   endtask

   task automatic test_cin;
      int lat, bc, dc;
      logic [W:0] sd, sa, exp_s;
      exp_s = CIN_EN ? 5'h1F : 5'h1E;
      do_op(4'hF, 4'hF, 1'b1, -1, 0, -10, lat, bc, dc, sd, sa);
      checks++;
      if (sd !== exp_s) begin
         errors++;
         $display("FAIL cin_sum got=%h expected %h", sd, exp_s);
      end
   endtask

   task automatic test_random;
      int lat, bc, dc, sk, sl, pk;
      logic [W-1:0] a, b;
      logic cin;
      logic [W:0] sd, sa, exp_s;
      for (int n = 0; n < 30; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         sl = $urandom_range(0, 3);
         sk = $urandom_range(0, W - 1);
         pk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, W) : -10;
         exp_s = model_sum(a, b, cin);
         do_op(a, b, cin, sk, sl, pk, lat, bc, dc, sd, sa);
         checks++;
         if (sd !== exp_s || sa !== exp_s || lat !== W + sl || dc !== 1) begin
            errors++;
            $display("FAIL random n=%0d a=%h b=%h cin=%b sum=%h held=%h lat=%0d dones=%0d expected %h lat %0d",
                     n, a, b, cin, sd, sa, lat, dc, exp_s, W + sl);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      bus.ena = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      set_cin(1'b0);
      test_reset;
      test_basic;
      test_back_to_back;
      test_start_ignored;
      test_stall;
      test_reset_mid;
      test_cin;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial multi-bit adder sequencer built around the half-adder cell. It captures two WIDTH-bit operands on a start strobe, adds them LSB-first at one bit per clock, and presents a WIDTH+1-bit result with a one-cycle done pulse. It sits directly downstream of the top-level pin mapping and upstream of the half-adder datapath. It drives the per-bit operands into the half-adder logic and consumes the sum and carry it returns. It is intended for the TinyTapeout wrapper: operands on ui_in, control and result on uio/uo.

## Interface
- WIDTH, 4, operand width in bits (2..8)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low = stall (all state holds)
- start  in  1  request; sampled only in IDLE with ena=1
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high while in ADD
- done  out  1  one-cycle pulse, high in DONE
- sum  out  WIDTH+1  result {carry_out, sum bits}, held until next completion

## Operation
- States: IDLE -> ADD -> DONE -> IDLE.
- IDLE:
  - If start & ena, load the a and b shift registers.
  - Clear the carry flop (or load cin, see Configuration) and the bit counter.
  - Go to ADD.
- ADD, each enabled cycle:
  - Compute the full add of a_sr[0], b_sr[0] and carry as two half-adder steps: s1 = a^b, c1 = a&b; s = s1^carry, c2 = s1&carry; carry_next = c1|c2.
  - Shift s into the MSB of the result shift register.
  - Shift a_sr and b_sr right.
  - Increment the counter.
  - After the WIDTH-th bit, go to DONE.
- On the ADD->DONE edge, copy {carry_next, result_sr} into the sum output register.
- DONE: done=1 for exactly one enabled cycle, then IDLE.
- start in ADD or DONE is ignored and not queued.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic: sum = a + b (+cin), unsigned, WIDTH+1 bits, no wrap.
- ena low: no state, counter, shift register or output changes; done and busy keep their current values.
- Reset values: busy=0, done=0, sum=0, state=IDLE, all internal registers 0.

## Timing
- The start accept edge is T.
- busy=1 from T to T+WIDTH.
- The result is written and done goes high at edge T+WIDTH.
- done falls and the state returns to IDLE at edge T+WIDTH+1.
- Latency from start to done is WIDTH cycles; throughput is one add per WIDTH+2 cycles.
- A start held high continuously is accepted again at edge T+WIDTH+2.
- ena deasserted for k cycles during ADD or DONE extends every subsequent edge by k.
- Reset asserted mid-operation immediately forces IDLE, clears sum, and drops busy and done; the partial result is discarded.
- After reset release, the first start is accepted on the first rising edge with rst_n=1, ena=1 and start=1.

## Configuration
- SERADD_CARRY_IN_EN
  - Defined: adds input port cin (1 bit), captured with the operands on an accepted start and loaded into the carry flop, so sum = a + b + cin.
  - Undefined: the cin port does not exist, the carry flop loads 0 on start, and sum = a + b.

## Test plan
- Reset then idle: rst_n low with clk running -> busy=0, done=0, sum=0; with start=0, outputs stay 0 for 20 cycles.
- WIDTH=4, a=0xF, b=0x1, start one cycle -> busy high 4 cycles, done pulses once at edge T+4, sum=0x10 held afterwards.
- a=0x5, b=0xA, then a=0x0, b=0x0 back-to-back with start held high -> sum=0x0F, then sum=0x00; second accept at T+6.
- Start pulsed during ADD with different operands -> ignored; sum matches the first operands; exactly one done pulse.
- ena low for 3 cycles mid-ADD on a=0x9, b=0x7 -> done delayed 3 cycles, sum=0x10; rst_n pulsed mid-ADD -> immediate busy=0, sum=0, no done.
- With SERADD_CARRY_IN_EN, a=0xF, b=0xF, cin=1 -> sum=0x1F; without the macro, same operands -> sum=0x1E.
